// File: rtl/fifo_param_if.sv
// Handshake and status bundle between a FIFO and its user.
// The FIFO side uses the slave modport; the producer/consumer side uses master.
interface fifo_param_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] din;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] dout;
  logic                  valid;
  logic                  empty;
  logic                  full;
  logic                  almost_empty;
  logic                  almost_full;
  logic [ADDR_WIDTH:0]   data_count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output din, wr_en, rd_en,
    input  dout, valid, empty, full, almost_empty, almost_full,
           data_count, overflow, underflow
  );

  modport slave (
    input  din, wr_en, rd_en,
    output dout, valid, empty, full, almost_empty, almost_full,
           data_count, overflow, underflow
  );
endinterface

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with standard or first-word-fall-through read,
// programmable almost flags, occupancy count and one-cycle error pulses.
// All status outputs are registered from the next-state occupancy so they agree
// with each other in every cycle.
module fifo_param #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 8,
  parameter int FWFT          = 0,
  parameter int AFULL_THRESH  = (2 ** ADDR_WIDTH) - 2,
  parameter int AEMPTY_THRESH = 2
) (
  input logic        clk,
  input logic        srst,
  fifo_param_if.slave bus
);

  localparam int                DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] AF_T      = AFULL_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_T      = AEMPTY_THRESH[ADDR_WIDTH:0];

  // Storage; contents survive reset on purpose, only pointers/count are cleared.
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q,  count_d;
  logic [DATA_WIDTH-1:0] dout_q,   dout_d;
  logic                  valid_q,  valid_d;
  logic                  empty_q,  empty_d;
  logic                  full_q,   full_d;
  logic                  aempty_q, aempty_d;
  logic                  afull_q,  afull_d;
  logic                  ovf_q,    ovf_d;
  logic                  unf_q,    unf_d;

  logic                  wr_acc;
  logic                  rd_acc;

  // Acceptance is judged against the registered flags, so a write while full
  // is refused even if a read frees a slot in the same cycle (and vice versa).
  assign wr_acc = bus.wr_en && !full_q;
  assign rd_acc = bus.rd_en && !empty_q;

  // Next-state pointers, occupancy, status flags and error pulses.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) begin
      wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    end
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
      2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
      default: count_d = count_q;
    endcase
    empty_d  = (count_d == '0);
    full_d   = (count_d == DEPTH_CNT);
    aempty_d = (count_d <= AE_T);
    afull_d  = (count_d >= AF_T);
    ovf_d    = bus.wr_en && !wr_acc;
    unf_d    = bus.rd_en && !rd_acc;
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head word tracks the next-state read pointer; when the head slot is the
      // one being written this cycle, forward din so a write into an empty FIFO
      // is visible one cycle later.
      always_comb begin
        dout_d  = dout_q;
        valid_d = (count_d != '0);
        if (count_d != '0) begin
          if (wr_acc && (wr_ptr_q == rd_ptr_d)) begin
            dout_d = bus.din;
          end else begin
            dout_d = mem[rd_ptr_d];
          end
        end
      end
    end else begin : g_std
      // Registered read: dout changes only on an accepted read, valid marks it.
      always_comb begin
        dout_d  = dout_q;
        valid_d = rd_acc;
        if (rd_acc) begin
          dout_d = mem[rd_ptr_q];
        end
      end
    end
  endgenerate

  // Storage write port; no reset so it maps onto plain register/RAM cells.
  always_ff @(posedge clk) begin
    if (wr_acc && !srst) begin
      mem[wr_ptr_q] <= bus.din;
    end
  end

  // State register with asynchronous clear of all control and output state.
  always_ff @(posedge clk or posedge srst) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      valid_q  <= 1'b0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      aempty_q <= 1'b1;
      afull_q  <= 1'b0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      valid_q  <= valid_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      aempty_q <= aempty_d;
      afull_q  <= afull_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  assign bus.dout         = dout_q;
  assign bus.valid        = valid_q;
  assign bus.empty        = empty_q;
  assign bus.full         = full_q;
  assign bus.almost_empty = aempty_q;
  assign bus.almost_full  = afull_q;
  assign bus.data_count   = count_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: one standard-mode and one FWFT instance side by side,
// checked every cycle against a queue-based model, plus a directed vector table
// and hand-written corner-case sequences.
module tb_fifo_param;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  logic clk = 1'b0;
  logic srst;

  always #5 clk = ~clk;

  fifo_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_s ();
  fifo_param_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_f ();

  fifo_param #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0),
    .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)
  ) dut_s (
    .clk(clk), .srst(srst), .bus(bus_s)
  );

  fifo_param #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1),
    .AFULL_THRESH(AF), .AEMPTY_THRESH(AE)
  ) dut_f (
    .clk(clk), .srst(srst), .bus(bus_f)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: contents as queues, plus the expected registered outputs.
  logic [7:0] q_s[$];
  logic [7:0] q_f[$];
  logic [7:0] ed[2];
  bit         ev[2];
  bit         eo[2];
  bit         eu[2];

  typedef struct {
    bit         wr;
    bit         rd;
    logic [7:0] din;
    int         cnt;
    logic [7:0] dout;
    bit         valid;
    bit         ae;
    bit         af;
    bit         full;
    bit         empty;
    bit         ovf;
    bit         unf;
  } vec_t;

  vec_t tbl[34];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q_s.delete();
    q_f.delete();
    for (int k = 0; k < 2; k++) begin
      ed[k] = 8'h00;
      ev[k] = 1'b0;
      eo[k] = 1'b0;
      eu[k] = 1'b0;
    end
  endtask

  // One clock edge of FIFO behaviour, decided from the occupancy before the edge.
  task automatic model_edge(inout logic [7:0] q[$], input bit fw, input bit w, input bit r,
                            input logic [7:0] d, inout logic [7:0] dq,
                            output bit v, output bit o, output bit u);
    int n;
    bit wa;
    bit ra;
    logic [7:0] head;
    n  = q.size();
    wa = w && (n < DEPTH);
    ra = r && (n > 0);
    o  = w && !wa;
    u  = r && !ra;
    if (ra) begin
      head = q.pop_front();
      if (!fw) dq = head;
    end
    if (wa) q.push_back(d);
    if (fw) begin
      v = (q.size() > 0);
      if (q.size() > 0) dq = q[0];
    end else begin
      v = ra;
    end
  endtask

  task automatic check_dut(input int k, input string tag);
    logic [7:0] a_d;
    logic       a_v, a_e, a_f, a_ae, a_af, a_o, a_u;
    logic [4:0] a_c;
    int         n;
    string      nm;
    if (k == 0) begin
      a_d = bus_s.dout; a_v = bus_s.valid; a_e = bus_s.empty; a_f = bus_s.full;
      a_ae = bus_s.almost_empty; a_af = bus_s.almost_full; a_c = bus_s.data_count;
      a_o = bus_s.overflow; a_u = bus_s.underflow; n = q_s.size(); nm = "std";
    end else begin
      a_d = bus_f.dout; a_v = bus_f.valid; a_e = bus_f.empty; a_f = bus_f.full;
      a_ae = bus_f.almost_empty; a_af = bus_f.almost_full; a_c = bus_f.data_count;
      a_o = bus_f.overflow; a_u = bus_f.underflow; n = q_f.size(); nm = "fwft";
    end
    cmp($sformatf("%s/%s/dout", tag, nm),  32'(a_d),  32'(ed[k]));
    cmp($sformatf("%s/%s/valid", tag, nm), 32'(a_v),  32'(ev[k]));
    cmp($sformatf("%s/%s/count", tag, nm), 32'(a_c),  n);
    cmp($sformatf("%s/%s/empty", tag, nm), 32'(a_e),  32'(n == 0));
    cmp($sformatf("%s/%s/full", tag, nm),  32'(a_f),  32'(n == DEPTH));
    cmp($sformatf("%s/%s/aempty", tag, nm), 32'(a_ae), 32'(n <= AE));
    cmp($sformatf("%s/%s/afull", tag, nm), 32'(a_af), 32'(n >= AF));
    cmp($sformatf("%s/%s/ovf", tag, nm),   32'(a_o),  32'(eo[k]));
    cmp($sformatf("%s/%s/unf", tag, nm),   32'(a_u),  32'(eu[k]));
  endtask

  // Advance one clock, update the model with the inputs present at the edge,
  // then check both instances.
  task automatic step(input string tag);
    bit         w0, r0, w1, r1;
    logic [7:0] d0, d1, t;
    bit         v, o, u;
    w0 = bus_s.wr_en; r0 = bus_s.rd_en; d0 = bus_s.din;
    w1 = bus_f.wr_en; r1 = bus_f.rd_en; d1 = bus_f.din;
    @(posedge clk);
    #1;
    t = ed[0];
    model_edge(q_s, 1'b0, w0, r0, d0, t, v, o, u);
    ed[0] = t; ev[0] = v; eo[0] = o; eu[0] = u;
    t = ed[1];
    model_edge(q_f, 1'b1, w1, r1, d1, t, v, o, u);
    ed[1] = t; ev[1] = v; eo[1] = o; eu[1] = u;
    $display("[TB] %s std wr=%0b rd=%0b din=%02h cnt=%0d dout=%02h | fwft wr=%0b rd=%0b din=%02h cnt=%0d dout=%02h",
             tag, w0, r0, d0, bus_s.data_count, bus_s.dout, w1, r1, d1, bus_f.data_count, bus_f.dout);
    check_dut(0, tag);
    check_dut(1, tag);
  endtask

  task automatic set_in(input bit w, input bit r, input logic [7:0] d);
    bus_s.wr_en = w; bus_s.rd_en = r; bus_s.din = d;
    bus_f.wr_en = w; bus_f.rd_en = r; bus_f.din = d;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    // Directed table: fill to full, one refused write, drain, one refused read.
    for (int i = 0; i < 16; i++) begin
      tbl[i] = '{wr: 1'b1, rd: 1'b0, din: 8'(i + 1), cnt: i + 1, dout: 8'h00, valid: 1'b0,
                 ae: ((i + 1) <= AE), af: ((i + 1) >= AF), full: ((i + 1) == DEPTH),
                 empty: 1'b0, ovf: 1'b0, unf: 1'b0};
    end
    tbl[16] = '{wr: 1'b1, rd: 1'b0, din: 8'hFF, cnt: 16, dout: 8'h00, valid: 1'b0,
                ae: 1'b0, af: 1'b1, full: 1'b1, empty: 1'b0, ovf: 1'b1, unf: 1'b0};
    for (int j = 0; j < 16; j++) begin
      tbl[17 + j] = '{wr: 1'b0, rd: 1'b1, din: 8'h00, cnt: 15 - j, dout: 8'(j + 1), valid: 1'b1,
                      ae: ((15 - j) <= AE), af: ((15 - j) >= AF), full: 1'b0,
                      empty: ((15 - j) == 0), ovf: 1'b0, unf: 1'b0};
    end
    tbl[33] = '{wr: 1'b0, rd: 1'b1, din: 8'h00, cnt: 0, dout: 8'h10, valid: 1'b0,
                ae: 1'b1, af: 1'b0, full: 1'b0, empty: 1'b1, ovf: 1'b0, unf: 1'b1};

    // Reset state
    srst = 1'b1;
    set_in(1'b0, 1'b0, 8'h00);
    model_reset();
    @(posedge clk);
    #1;
    check_dut(0, "reset");
    check_dut(1, "reset");
    srst = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < 34; i++) begin
      set_in(tbl[i].wr, tbl[i].rd, tbl[i].din);
      step($sformatf("vec%0d", i));
      cmp($sformatf("vec%0d/count", i), 32'(bus_s.data_count), tbl[i].cnt);
      cmp($sformatf("vec%0d/dout", i),  32'(bus_s.dout),  32'(tbl[i].dout));
      cmp($sformatf("vec%0d/valid", i), 32'(bus_s.valid), 32'(tbl[i].valid));
      cmp($sformatf("vec%0d/aempty", i), 32'(bus_s.almost_empty), 32'(tbl[i].ae));
      cmp($sformatf("vec%0d/afull", i), 32'(bus_s.almost_full), 32'(tbl[i].af));
      cmp($sformatf("vec%0d/full", i),  32'(bus_s.full),  32'(tbl[i].full));
      cmp($sformatf("vec%0d/empty", i), 32'(bus_s.empty), 32'(tbl[i].empty));
      cmp($sformatf("vec%0d/ovf", i),   32'(bus_s.overflow),  32'(tbl[i].ovf));
      cmp($sformatf("vec%0d/unf", i),   32'(bus_s.underflow), 32'(tbl[i].unf));
    end

    // Full with simultaneous read and write: read wins, write refused
    for (int i = 0; i < 16; i++) begin
      set_in(1'b1, 1'b0, 8'(8'h40 + i));
      step("fill");
    end
    set_in(1'b1, 1'b1, 8'hEE);
    step("full_rw");
    cmp("full_rw/count", 32'(bus_s.data_count), 15);
    cmp("full_rw/ovf", 32'(bus_s.overflow), 1);
    cmp("full_rw/dout", 32'(bus_s.dout), 32'h40);

    // Drain to 5, then 40 cycles of concurrent read/write
    for (int i = 0; i < 10; i++) begin
      set_in(1'b0, 1'b1, 8'h00);
      step("drain");
    end
    for (int i = 0; i < 40; i++) begin
      set_in(1'b1, 1'b1, 8'(8'h80 + i));
      step("rw40");
    end
    cmp("rw40/count", 32'(bus_s.data_count), 5);
    cmp("rw40/dout", 32'(bus_s.dout), 32'h80 + 34);

    // Empty with simultaneous read and write: write wins, read refused
    for (int i = 0; i < 5; i++) begin
      set_in(1'b0, 1'b1, 8'h00);
      step("drain");
    end
    set_in(1'b1, 1'b1, 8'h5A);
    step("empty_rw");
    cmp("empty_rw/count", 32'(bus_s.data_count), 1);
    cmp("empty_rw/unf", 32'(bus_s.underflow), 1);
    set_in(1'b0, 1'b1, 8'h00);
    step("drain");
    cmp("empty_rw/dout", 32'(bus_s.dout), 32'h5A);

    // Asynchronous reset in the middle of operation
    for (int i = 0; i < 9; i++) begin
      set_in(1'b1, 1'b0, 8'(8'h90 + i));
      step("pre_rst");
    end
    set_in(1'b0, 1'b0, 8'h00);
    srst = 1'b1;
    #1;
    model_reset();
    check_dut(0, "async_rst");
    check_dut(1, "async_rst");
    cmp("async_rst/count", 32'(bus_s.data_count), 0);
    @(posedge clk);
    #1;
    srst = 1'b0;
    set_in(1'b1, 1'b0, 8'h3C);
    step("post_rst_wr");
    set_in(1'b0, 1'b1, 8'h00);
    step("post_rst_rd");
    cmp("post_rst/dout", 32'(bus_s.dout), 32'h3C);
    cmp("post_rst/valid", 32'(bus_s.valid), 1);

    // FWFT: written word appears without a request, pop empties it
    set_in(1'b0, 1'b0, 8'h00);
    bus_f.wr_en = 1'b1;
    bus_f.din   = 8'hA5;
    step("fwft_wr");
    cmp("fwft_wr/dout", 32'(bus_f.dout), 32'hA5);
    cmp("fwft_wr/valid", 32'(bus_f.valid), 1);
    bus_f.wr_en = 1'b0;
    bus_f.rd_en = 1'b1;
    step("fwft_rd");
    cmp("fwft_rd/empty", 32'(bus_f.empty), 1);
    cmp("fwft_rd/valid", 32'(bus_f.valid), 0);
    cmp("fwft_rd/dout", 32'(bus_f.dout), 32'hA5);

    // Randomised traffic in phases biased toward full, empty, then balanced
    for (int i = 0; i < 1200; i++) begin
      int pw;
      int pr;
      case (i / 300)
        0:       begin pw = 80; pr = 25; end
        1:       begin pw = 20; pr = 80; end
        default: begin pw = 50; pr = 50; end
      endcase
      bus_s.wr_en = ($urandom_range(99) < pw);
      bus_s.rd_en = ($urandom_range(99) < pr);
      bus_s.din   = 8'($urandom);
      bus_f.wr_en = ($urandom_range(99) < pw);
      bus_f.rd_en = ($urandom_range(99) < pr);
      bus_f.din   = 8'($urandom);
      step($sformatf("rnd%0d", i));
    end

    set_in(1'b0, 1'b0, 8'h00);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fifo_param.md
# fifo_param

Parametrised synchronous FIFO; successor to the fixed 8-bit × 256 byte queue used by the randomization-queue datapath. Adds configurable width and depth, a first-word-fall-through (FWFT) read mode, programmable almost-full and almost-empty flags, an occupancy count, a read-valid strobe, and sticky-free overflow and underflow error pulses. Sits between the packet producer and the consumer logic, on a single clock domain.

## Interface
- DATA_WIDTH, 8: width of din and dout in bits.
- ADDR_WIDTH, 8: pointer width. DEPTH = 2**ADDR_WIDTH entries.
- FWFT, 0: read mode. 0 = standard registered read; 1 = first-word-fall-through.
- AFULL_THRESH, DEPTH-2: almost_full asserts when count >= AFULL_THRESH. Legal range is 1..DEPTH.
- AEMPTY_THRESH, 2: almost_empty asserts when count <= AEMPTY_THRESH. Legal range is 0..DEPTH-1.
- clk  input  1  system clock; all state changes on its rising edge.
- srst  input  1  reset. Asynchronous, active-high; already decided.
- din  input  DATA_WIDTH  write data.
- wr_en  input  1  write request.
- rd_en  input  1  read request. In FWFT mode it acknowledges (pops) the word currently on dout.
- dout  output  DATA_WIDTH  read data.
- valid  output  1  standard mode: dout was updated by a read accepted in the previous cycle. FWFT mode: equals !empty.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- almost_empty  output  1  count <= AEMPTY_THRESH.
- almost_full  output  1  count >= AFULL_THRESH.
- data_count  output  ADDR_WIDTH+1  current occupancy, 0..DEPTH.
- overflow  output  1  one-cycle pulse: a write was rejected in the previous cycle.
- underflow  output  1  one-cycle pulse: a read was rejected in the previous cycle.

## Operation
- Storage is a DEPTH × DATA_WIDTH register array. Pointers wr_ptr and rd_ptr are ADDR_WIDTH wide and wrap naturally from DEPTH-1 to 0. An (ADDR_WIDTH+1)-bit counter holds occupancy.
- A write is accepted when wr_en && !full. The array is written at wr_ptr, and wr_ptr increments.
- A read is accepted when rd_en && !empty, and rd_ptr increments.
- Acceptance is evaluated against the flags as they stand at the clock edge:
  - A write while full is rejected even if a read is accepted in the same cycle.
  - A read while empty is rejected even if a write is accepted in the same cycle.
- Count update per cycle: +1 for a write only, -1 for a read only, unchanged when both or neither are accepted.
- All flags and data_count are registered and derived from the next-state count, so they are mutually consistent every cycle.
- Standard mode (FWFT=0):
  - An accepted read loads dout <= mem[rd_ptr].
  - dout holds its value otherwise.
  - valid pulses for one cycle after each accepted read.
- FWFT mode (FWFT=1):
  - dout = mem[rd_ptr] whenever !empty, so the head word is visible without a request.
  - rd_en pops the head word.
  - When empty, dout holds its last value.
- Rejected operations do not alter memory, pointers or count. They only raise overflow or underflow.
- Reset values: all pointers 0, count 0, dout 0, valid 0, empty 1, full 0, almost_empty 1, almost_full 0, data_count 0, overflow 0, underflow 0. Memory contents are not reset.
- Reset asserted mid-operation discards all stored data immediately (asynchronously). Operation resumes on the first rising clk edge after srst falls.

## Timing
- Write to visibility:
  - Write accepted at edge N: data_count, empty, almost flags and full reflect it after edge N.
  - A read issued in the cycle after N is accepted.
- Standard read latency: rd_en accepted at edge N puts the data on dout, with valid=1, after edge N (one cycle).
- FWFT latency: a write into an empty FIFO at edge N drives dout with that word and sets valid=1 after edge N.
- overflow and underflow assert for exactly one cycle, after the edge at which the request was rejected.
- Back-to-back reads and writes sustain one word per cycle in each direction.
- Full transition: full asserts after the DEPTH-th net write. It deasserts after the first accepted read.
- Pointer wrap: pointers roll over without a bubble.

## Test plan
- Reset and flags: DATA_WIDTH=8, ADDR_WIDTH=4, thresholds 14 and 2. Write 0x01..0x10 → count steps 1..16; almost_empty drops at count 3; almost_full rises at 14; full rises at 16. A 17th write (0xFF) → overflow pulse, count stays 16.
- Standard read order: drain the FIFO → dout = 0x01..0x10 in order, each valid one cycle after rd_en. A 17th read → underflow pulse, dout holds 0x10, empty=1.
- Simultaneous read and write: with count 5, assert wr_en and rd_en for 40 cycles → count stays 5, no gaps in the data order, and pointers wrap at least twice.
- Edge cases: with full asserted, wr_en and rd_en together → read accepted, write rejected, overflow pulses, count goes to 15. With empty asserted, both together → write accepted, underflow pulses, count goes to 1.
- FWFT mode (FWFT=1): write 0xA5 into an empty FIFO → dout=0xA5 and valid=1 on the next cycle with no rd_en. rd_en → empty=1 and valid=0 on the following cycle.
- Mid-operation reset: with count 9, pulse srst between clock edges → all outputs take their reset values immediately. After release, write 0x3C and read it → dout=0x3C.
